// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline hazard/MDU control bundle between the core datapath (master) and
// the stall controller (slave).
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_use_stall;
    logic             branch_taken;
    logic             md_start;
    logic             md_is_div;
    logic             hilo_use;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             md_go;
    logic             md_busy;
    logic             hilo_wr;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output load_use_stall, branch_taken, md_start, md_is_div, hilo_use,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush,
        input  md_go, md_busy, hilo_wr, stall_cnt
    );

    modport slave (
        input  load_use_stall, branch_taken, md_start, md_is_div, hilo_use,
        output pc_en, if_id_en, if_id_flush, id_ex_flush,
        output md_go, md_busy, hilo_wr, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: merges load-use stalls, branch redirects and
// MDU scheduling into per-stage enable/flush controls plus a stall counter.
module pipe_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stall_ctrl_if.slave     bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] MUL_M1 = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_M1 = 6'(DIV_LAT - 1);

    state_t           state, state_nxt;
    logic [5:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall;
    logic             pc_en, if_id_en, if_id_flush, id_ex_flush;
    logic             md_go, hilo_wr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (MUL_LAT >= 1 && MUL_LAT <= 63 && DIV_LAT >= 1 && DIV_LAT <= 63)
                else $error("pipe_stall_ctrl: MDU latency parameter out of 1..63");
        end
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_en && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Outputs are forced to their quiescent values while rst is high so an
    // aborted MDU operation can never strobe hilo_wr.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        md_go       = 1'b0;
        hilo_wr     = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        stall       = bus.load_use_stall ||
                      (state == RUN && (bus.hilo_use || bus.md_start));

        if (!rst) begin
            if (bus.branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (stall) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.md_start && !bus.load_use_stall && !bus.branch_taken) begin
                        md_go     = 1'b1;
                        state_nxt = RUN;
                        cnt_nxt   = bus.md_is_div ? DIV_M1 : MUL_M1;
                    end
                end
                RUN: begin
                    // Branches do not cancel: the issuing instruction is older.
                    if (cnt == 6'd0) begin
                        hilo_wr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
            endcase
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.if_id_en    = if_id_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.md_go       = md_go;
    assign bus.md_busy     = (state == RUN);
    assign bus.hilo_wr     = hilo_wr;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule
